// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, frame constants and helpers
//
// Contents:
//   rx_state_e            receiver FSM state encoding
//   DEFAULT_CLKS_PER_BIT  100 MHz / 115200 baud
//   DATA_BITS, STOP_BITS, PARITY_BITS, FRAME_BITS  frame geometry
//   even_parity()         parity bit that makes the byte plus parity even
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;
`ifdef UART_RX_PARITY_EN
  localparam int PARITY_BITS          = 1;
`else
  localparam int PARITY_BITS          = 0;
`endif
  localparam int FRAME_BITS           = 1 + DATA_BITS + PARITY_BITS + STOP_BITS;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// rtl/uart_rx_buffer_if.sv - read/status bus between the receive buffer and its consumer
//
// Signals:
//   data_out    FIFO head byte (first-word fall-through)
//   data_valid  FIFO non-empty
//   count       occupancy, $clog2(DEPTH)+1 bits
//   overrun     sticky: byte dropped on full FIFO
//   frame_err   sticky: stop bit sampled low
//   parity_err  sticky: even-parity mismatch (0 in 8N1 builds)
//   rd_en       pop request
//   clr_err     clears the sticky flags
// Modports: master = receive buffer side, slave = consumer side.
interface uart_rx_buffer_if #(
  parameter int DEPTH = 16
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       data_out;
  logic             data_valid;
  logic [CNT_W-1:0] count;
  logic             overrun;
  logic             frame_err;
  logic             parity_err;
  logic             rd_en;
  logic             clr_err;

  modport master (
    output data_out, data_valid, count, overrun, frame_err, parity_err,
    input  rd_en, clr_err
  );

  modport slave (
    input  data_out, data_valid, count, overrun, frame_err, parity_err,
    output rd_en, clr_err
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word fall-through FIFO
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers/count only)
//   wr_en        push request, wr_data stored when accepted
//   rd_en        pop request, ignored while empty
//   rd_data      head entry, valid while rd_valid
//   count        occupancy 0..DEPTH, never wraps
//   overflow     push refused this cycle (full and no pop)
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = wr_en && (!full || do_pop);
  assign overflow = wr_en && full && !rd_en;

  assign rd_data  = mem[rd_ptr];
  assign rd_valid = !empty;

  // When full with push+pop, wr_ptr == rd_ptr: the head is read out this
  // cycle and overwritten at the same edge rd_ptr moves past it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a byte FIFO
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   uart_txd_in  asynchronous serial line, idle high
//   bus          uart_rx_buffer_if.master: data_out, data_valid, count,
//                overrun, frame_err, parity_err out; rd_en, clr_err in
// Parameters: CLKS_PER_BIT (>= 4), DEPTH (power of two, 2..256).
// Build option: define UART_RX_PARITY_EN for 8E1 framing with parity check.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_txd_in,
  uart_rx_buffer_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  // Synchronizer plus one history flop for falling-edge detection.
  logic sync_q1;
  logic rx_s;
  logic rx_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_q1 <= uart_txd_in;
      rx_s    <= sync_q1;
      rx_prev <= rx_s;
    end
  end

  rx_state_e     state, state_d;
  logic [CW-1:0] clk_cnt, clk_cnt_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    shift, shift_d;
  logic          push_q, push_d;
  logic          frame_set;
  logic          par_set;
`ifdef UART_RX_PARITY_EN
  logic          par_bad, par_bad_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      push_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      clk_cnt <= clk_cnt_d;
      bit_cnt <= bit_cnt_d;
      shift   <= shift_d;
      push_q  <= push_d;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    clk_cnt_d = clk_cnt;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    push_d    = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad;
`endif
    unique case (state)
      ST_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_d   = ST_START;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (clk_cnt == HALF_CNT) begin
          // Line back high at mid-start: a glitch, drop silently.
          clk_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift[7:1]};
          bit_cnt_d = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_d = '0;
          state_d   = ST_STOP;
          if (rx_s != even_parity(shift)) begin
            par_set   = 1'b1;
            par_bad_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_d = '0;
          state_d   = ST_IDLE;
          if (!rx_s) begin
            frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (!par_bad) begin
`else
          end else begin
`endif
            push_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // push_q is registered, so the FIFO write lands one edge after the
  // stop sample; shift is untouched in IDLE and still holds the byte.
  logic [7:0]                fifo_data;
  logic                      fifo_valid;
  logic [$clog2(DEPTH):0]    fifo_count;
  logic                      fifo_overflow;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (push_q),
    .wr_data  (shift),
    .rd_en    (bus.rd_en),
    .rd_data  (fifo_data),
    .rd_valid (fifo_valid),
    .count    (fifo_count),
    .overflow (fifo_overflow)
  );

  // Sticky flags: a set event in the same cycle beats clr_err.
  logic frame_err_q;
  logic overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (frame_set)          frame_err_q <= 1'b1;
      else if (bus.clr_err)   frame_err_q <= 1'b0;
      if (fifo_overflow)      overrun_q   <= 1'b1;
      else if (bus.clr_err)   overrun_q   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else if (par_set) begin
      parity_err_q <= 1'b1;
    end else if (bus.clr_err) begin
      parity_err_q <= 1'b0;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data_out   = fifo_data;
  assign bus.data_valid = fifo_valid;
  assign bus.count      = fifo_count;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - self-checking bench for uart_rx_buffer (CLKS_PER_BIT=4, DEPTH=4)
module tb_uart_rx_buffer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;

  uart_rx_buffer_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_buffer #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_txd_in (rxd),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         cnt;
    logic [7:0] head;
    logic       fe;
    logic       ov;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Returns on the negedge that ends the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    send_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    chk("pop_valid", bus.data_valid, 1);
    chk("pop_data", bus.data_out, exp);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rxd = 1'b1;
    bus.rd_en = 1'b0;
    bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.data_valid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_parity_err", bus.parity_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] q [$];
  logic       fe_m;
  logic       ov_m;
  logic [7:0] rb;
  logic       rgood;
  int         npop;

  initial begin
    vecs[0] = '{8'h01, 1'b1, 1, 8'h01, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 1'b1, 2, 8'h01, 1'b0, 1'b0};
    vecs[2] = '{8'h03, 1'b1, 3, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 3, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{8'h04, 1'b1, 4, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{8'h05, 1'b1, 4, 8'h01, 1'b1, 1'b1};

    bus.rd_en = 1'b0;
    bus.clr_err = 1'b0;
    do_reset();

    // Fill, frame error in the middle, overflow at the end.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      settle();
      chk("tbl_count", bus.count, vecs[i].cnt);
      chk("tbl_head", bus.data_out, vecs[i].head);
      chk("tbl_frame_err", bus.frame_err, vecs[i].fe);
      chk("tbl_overrun", bus.overrun, vecs[i].ov);
    end
    for (int i = 1; i <= 4; i++) pop_expect(8'(i));
    chk("drain_count", bus.count, 0);
    chk("drain_valid", bus.data_valid, 0);
    clr_pulse();
    chk("clr_frame_err", bus.frame_err, 0);
    chk("clr_overrun", bus.overrun, 0);

    // Push and pop together while full: no overrun, count stays.
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
      settle();
    end
    send_frame(8'h14, 1'b1, 1'b0);
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    @(negedge clk);
    chk("pp_count", bus.count, 4);
    chk("pp_overrun", bus.overrun, 0);
    for (int i = 1; i <= 4; i++) pop_expect(8'h10 + 8'(i));

    // Exact latency: visible one cycle after the stop sample.
    send_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_valid_early", bus.data_valid, 0);
    @(negedge clk);
    chk("lat_valid", bus.data_valid, 1);
    chk("lat_count", bus.count, 1);
    pop_expect(8'hA5);
    chk("a5_valid_after_pop", bus.data_valid, 0);
    chk("a5_count_after_pop", bus.count, 0);

    // Pop on empty is ignored.
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("empty_pop_count", bus.count, 0);
    chk("empty_pop_valid", bus.data_valid, 0);
    send_frame(8'h11, 1'b1, 1'b0);
    settle();
    chk("after_empty_count", bus.count, 1);
    pop_expect(8'h11);

    // Frame error with clr_err asserted on the same edge: set wins.
    send_frame(8'h3C, 1'b0, 1'b0);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("fe_set_wins", bus.frame_err, 1);
    settle();
    chk("fe_count", bus.count, 0);
    clr_pulse();
    chk("fe_cleared", bus.frame_err, 0);

    // Short low glitch: nothing stored, no error, receiver still aligned.
    @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_count", bus.count, 0);
    chk("glitch_frame_err", bus.frame_err, 0);
    chk("glitch_overrun", bus.overrun, 0);
    send_frame(8'h96, 1'b1, 1'b0);
    settle();
    chk("post_glitch_count", bus.count, 1);
    chk("post_glitch_head", bus.data_out, 8'h96);

    // Reset in data bit 4 with a byte already buffered.
    @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.data_valid, 0);
    chk("async_rst_count", bus.count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0);
    settle();
    chk("mid_rst_count", bus.count, 1);
    pop_expect(8'h5A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    settle();
    chk("par_err_set", bus.parity_err, 1);
    chk("par_err_count", bus.count, 0);
    clr_pulse();
    send_frame(8'h07, 1'b1, 1'b0);
    settle();
    chk("par_ok_err", bus.parity_err, 0);
    chk("par_ok_count", bus.count, 1);
    pop_expect(8'h07);
`endif

    // Randomized frames and pops against a queue model.
    do_reset();
    fe_m = 1'b0;
    ov_m = 1'b0;
    for (int it = 0; it < 40; it++) begin
      rb = 8'($urandom);
      rgood = ($urandom_range(0, 4) != 0);
      send_frame(rb, rgood, 1'b0);
      settle();
      if (!rgood) fe_m = 1'b1;
      else if (q.size() == DEPTH) ov_m = 1'b1;
      else q.push_back(rb);
      chk("rnd_count", bus.count, q.size());
      chk("rnd_frame_err", bus.frame_err, fe_m);
      chk("rnd_overrun", bus.overrun, ov_m);
      if (q.size() > 0) chk("rnd_head", bus.data_out, q[0]);
      else chk("rnd_valid", bus.data_valid, 0);
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        if (q.size() > 0) begin
          pop_expect(q.pop_front());
        end else begin
          bus.rd_en = 1'b1;
          @(negedge clk);
          bus.rd_en = 1'b0;
          chk("rnd_empty_pop", bus.count, 0);
        end
      end
      if ($urandom_range(0, 5) == 0) begin
        clr_pulse();
        fe_m = 1'b0;
        ov_m = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL timeout: got no finish, expected finish before 1 ms");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
